ip_hdr_preprocess: RTL
======================

Name: ip_hdr_preprocess

Overview:
Header-tracking stage at the front of the CAM router output-port-lookup pipeline. It monitors the 64-bit data/ctrl bus and raises word-position strobes aligned with the bus word. The destination-IP filter and the other lookup blocks use these strobes to capture header fields. It also pushes a per-packet sanity record (IPv4, IHL, TTL, short packet, input port) into a small fall-through FIFO that the process block reads once per packet.

Parameters:
DATA_WIDTH, 64, bus data width; fixed at 64 because the field offsets below assume it
CTRL_WIDTH, 8, bus ctrl width
IOQ_CTRL, 8'hFF, ctrl value marking the IO-queue module header
INFO_DEPTH_BITS, 2, log2 of the info FIFO depth (4 entries)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_data  in  64  bus data
in_ctrl  in  8  bus ctrl
in_wr  in  1  a word is transferred this cycle
word_ETH_DA_SA  out  1  pkt word 1 on bus (combinational)
word_ETH_SA_TYPE  out  1  pkt word 2 on bus
word_IP_LEN_TTL  out  1  pkt word 3 on bus
word_IP_SRC_DST  out  1  pkt word 4 on bus
word_IP_DST_LO  out  1  pkt word 5 on bus
pkt_info_vld  out  1  info FIFO not empty
pkt_info  out  7  {src_port[2:0], pkt_short, ttl_ok, ihl_ok, is_ipv4}, FIFO head
rd_pkt_info  in  1  pop the FIFO head
pkt_info_overflow  out  1  sticky: a push was dropped

Behaviour:
- Strobes: combinational, each equals in_wr AND the matching state. Word 1 additionally requires in_ctrl==0. A strobe is high in the same cycle its word is on in_data.
- FSM states: MOD_HDRS, W2, W3, W4, W5, PAYLOAD.
  - MOD_HDRS: on in_wr with in_ctrl==IOQ_CTRL, latch src_port <= in_data[18:16]. Other nonzero ctrl words are ignored. On in_wr with in_ctrl==0, this is word 1 -> W2.
  - W2: latch ethertype in_data[31:16] and ver/ihl in_data[15:8].
  - W3: latch ttl in_data[15:8].
  - W4: no latch.
  - Any of W2/W3/W4: on in_wr with in_ctrl==0, advance to the next state. With in_ctrl!=0 (early EOP), push a record with pkt_short=1 and go to MOD_HDRS.
  - W5: on in_wr, push the full record. If in_ctrl!=0 go to MOD_HDRS, else go to PAYLOAD.
  - PAYLOAD: on in_wr with in_ctrl!=0 (EOP), go to MOD_HDRS.
- Record fields:
  - is_ipv4 = (ethertype==16'h0800) && (version==4).
  - ihl_ok = (ihl==5).
  - ttl_ok = (ttl>1), unsigned 8-bit.
  - On a short packet, only fields already latched are meaningful; is_ipv4, ihl_ok and ttl_ok are forced to 0.
  - src_port is carried from the last IOQ header. It resets to 0 and is not cleared between packets.
- Info FIFO: fall-through, 2**INFO_DEPTH_BITS entries.
  - pkt_info_vld = !empty; pkt_info shows the head combinationally.
  - rd_pkt_info pops one entry. A pop while empty is ignored.
  - Push while full without a simultaneous pop: the record is dropped and pkt_info_overflow is set (cleared only by reset).
  - Push and pop in the same cycle while full: both succeed and the count is unchanged.
  - Push and pop in the same cycle while empty: the entry is written, pkt_info_vld=1 from the next cycle, and the pop is ignored.
- Latency: strobes have 0 cycles. The record is visible on pkt_info_vld the cycle after the W5 word or the early-EOP word.
- Reset values: state=MOD_HDRS, all strobes 0, FIFO empty, pkt_info_vld=0, pkt_info=0, pkt_info_overflow=0, latched fields 0.
- Reset mid-packet returns to MOD_HDRS and flushes the FIFO. Remaining words of the interrupted packet count as module headers until a ctrl==0 word arrives; the bench must not rely on that packet.
- in_wr=0 cycles: no state change and all strobes low. Bubbles between any words are legal.

Test Plan:
- IOQ hdr (src port 3) + IPv4 pkt: ethertype 0800, ver/ihl 45, ttl 40, 8 words. -> strobes pulse exactly on words 1-5. One record {3,0,1,1,1} is vld the cycle after word 5; after rd_pkt_info, vld=0.
- Same pkt with ttl=1, then another with ihl=6. -> records ttl_ok=0 and ihl_ok=0 respectively; other fields 1.
- ARP frame (ethertype 0806), 8 words. -> record is_ipv4=0. All five strobes still pulse.
- 3-word pkt with EOP on word 3. -> word_IP_SRC_DST and word_IP_DST_LO never pulse. Record {port,1,0,0,0}. The next packet's strobes are correct.
- Five back-to-back packets with no reads. -> 4 records held, 5th dropped, pkt_info_overflow=1. Then push+pop in the same cycle when full keeps 4 entries.
- Reset asserted during word 3, then a new packet, with random in_wr bubbles throughout. -> FIFO empty, overflow=0, and the new packet produces a correct single record.

Source files
------------

// File: rtl/ip_hdr_preprocess.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : ip_hdr_preprocess
//  Description : Header-tracking front end of the output-port-lookup
//                pipeline. Follows packets on the 64-bit data/ctrl bus,
//                raises combinational word-position strobes for header
//                words 1..5, and queues one sanity record per packet in a
//                small fall-through FIFO.
//
//  Ports
//    clk, reset          : clock, synchronous active-high reset
//    in_data/in_ctrl     : bus word and its ctrl byte
//    in_wr               : a bus word is transferred this cycle
//    word_ETH_DA_SA      : packet word 1 on the bus (needs in_ctrl == 0)
//    word_ETH_SA_TYPE    : packet word 2 on the bus
//    word_IP_LEN_TTL     : packet word 3 on the bus
//    word_IP_SRC_DST     : packet word 4 on the bus
//    word_IP_DST_LO      : packet word 5 on the bus
//    pkt_info_vld        : info FIFO holds at least one record
//    pkt_info            : FIFO head {src_port[2:0], pkt_short, ttl_ok,
//                          ihl_ok, is_ipv4}; zero while the FIFO is empty
//    rd_pkt_info         : pop the FIFO head
//    pkt_info_overflow   : sticky, set when a record had to be dropped
//
//  Revision    : 1.0 - initial release
// ============================================================================
module ip_hdr_preprocess #(
   parameter int                    DATA_WIDTH      = 64,
   parameter int                    CTRL_WIDTH      = 8,
   parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL        = 8'hFF,
   parameter int                    INFO_DEPTH_BITS = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic                  in_wr,
   output logic                  word_ETH_DA_SA,
   output logic                  word_ETH_SA_TYPE,
   output logic                  word_IP_LEN_TTL,
   output logic                  word_IP_SRC_DST,
   output logic                  word_IP_DST_LO,
   output logic                  pkt_info_vld,
   output logic [6:0]            pkt_info,
   input  logic                  rd_pkt_info,
   output logic                  pkt_info_overflow
);

   // ------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------
   localparam int INFO_DEPTH = 2 ** INFO_DEPTH_BITS;
   localparam logic [INFO_DEPTH_BITS:0] C_FIFO_FULL =
      (INFO_DEPTH_BITS + 1)'(INFO_DEPTH);

   localparam logic [15:0] C_ETHTYPE_IPV4 = 16'h0800;
   localparam logic [3:0]  C_IP_VERSION   = 4'd4;
   localparam logic [3:0]  C_IHL_NO_OPT   = 4'd5;

   // Packet-position states; W2..W5 mean "the next word is word N".
   localparam logic [2:0] S_MOD_HDRS = 3'd0;
   localparam logic [2:0] S_W2       = 3'd1;
   localparam logic [2:0] S_W3       = 3'd2;
   localparam logic [2:0] S_W4       = 3'd3;
   localparam logic [2:0] S_W5       = 3'd4;
   localparam logic [2:0] S_PAYLOAD  = 3'd5;

   // ------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------
   logic [2:0]                 r_state;
   logic [2:0]                 w_state_nxt;
   logic                       w_ctrl_zero;
   logic                       w_push;
   logic                       w_short;

   logic [2:0]                 r_src_port;
   logic [15:0]                r_ethertype;
   logic [7:0]                 r_ver_ihl;
   logic [7:0]                 r_ttl;

   logic                       w_is_ipv4;
   logic                       w_ihl_ok;
   logic                       w_ttl_ok;
   logic [6:0]                 w_rec;

   logic [6:0]                 r_mem [INFO_DEPTH];
   logic [INFO_DEPTH_BITS-1:0] r_wr_ptr;
   logic [INFO_DEPTH_BITS-1:0] r_rd_ptr;
   logic [INFO_DEPTH_BITS:0]   r_count;
   logic                       w_empty;
   logic                       w_full;
   logic                       w_fifo_wr;
   logic                       w_fifo_rd;
   logic                       r_overflow;

   // Only bits [31:8] of a bus word carry fields this block looks at.
   logic                       w_unused_data;
   assign w_unused_data = ^{in_data[DATA_WIDTH-1:32], in_data[7:0]};

   assign w_ctrl_zero = (in_ctrl == '0);

   // ------------------------------------------------------------------
   // Word-position strobes: purely combinational so a capture block can
   // grab the field in the very cycle the word is on in_data.
   // ------------------------------------------------------------------
   assign word_ETH_DA_SA   = in_wr && (r_state == S_MOD_HDRS) && w_ctrl_zero;
   assign word_ETH_SA_TYPE = in_wr && (r_state == S_W2);
   assign word_IP_LEN_TTL  = in_wr && (r_state == S_W3);
   assign word_IP_SRC_DST  = in_wr && (r_state == S_W4);
   assign word_IP_DST_LO   = in_wr && (r_state == S_W5);

   // ------------------------------------------------------------------
   // Next state and record push
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_short     = 1'b0;
      if (in_wr) begin
         case (r_state)
            S_MOD_HDRS: begin
               // Non-zero ctrl words here are module headers; the first
               // ctrl==0 word is packet word 1.
               if (w_ctrl_zero) begin
                  w_state_nxt = S_W2;
               end
            end
            S_W2, S_W3, S_W4: begin
               if (w_ctrl_zero) begin
                  w_state_nxt = r_state + 3'd1;
               end else begin
                  // Packet ended before word 5: record it as short.
                  w_push      = 1'b1;
                  w_short     = 1'b1;
                  w_state_nxt = S_MOD_HDRS;
               end
            end
            S_W5: begin
               w_push      = 1'b1;
               w_state_nxt = w_ctrl_zero ? S_PAYLOAD : S_MOD_HDRS;
            end
            S_PAYLOAD: begin
               if (!w_ctrl_zero) begin
                  w_state_nxt = S_MOD_HDRS;
               end
            end
            default: begin
               w_state_nxt = S_MOD_HDRS;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_MOD_HDRS;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Header field capture. src_port deliberately survives across packets:
   // a packet without its own IO-queue header inherits the last one.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_src_port  <= 3'd0;
         r_ethertype <= 16'd0;
         r_ver_ihl   <= 8'd0;
         r_ttl       <= 8'd0;
      end else if (in_wr) begin
         case (r_state)
            S_MOD_HDRS: begin
               if (in_ctrl == IOQ_CTRL) begin
                  r_src_port <= in_data[18:16];
               end
            end
            S_W2: begin
               r_ethertype <= in_data[31:16];
               r_ver_ihl   <= in_data[15:8];
            end
            S_W3: begin
               r_ttl <= in_data[15:8];
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Record assembly. The full record is pushed on word 5, by which time
   // ethertype, version/IHL and TTL are all registered.
   // ------------------------------------------------------------------
   assign w_is_ipv4 = (r_ethertype == C_ETHTYPE_IPV4) &&
                      (r_ver_ihl[7:4] == C_IP_VERSION);
   assign w_ihl_ok  = (r_ver_ihl[3:0] == C_IHL_NO_OPT);
   assign w_ttl_ok  = (r_ttl > 8'd1);

   assign w_rec = w_short ? {r_src_port, 1'b1, 3'b000}
                          : {r_src_port, 1'b0, w_ttl_ok, w_ihl_ok, w_is_ipv4};

   // ------------------------------------------------------------------
   // Fall-through info FIFO
   // ------------------------------------------------------------------
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == C_FIFO_FULL);

   // A pop while empty is ignored, so a simultaneous push into an empty
   // FIFO is simply a push. When full, a same-cycle pop frees the slot.
   assign w_fifo_rd = rd_pkt_info && !w_empty;
   assign w_fifo_wr = w_push && (!w_full || rd_pkt_info);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_fifo_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_fifo_rd) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_fifo_wr, w_fifo_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_fifo_wr) begin
         r_mem[r_wr_ptr] <= w_rec;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (w_push && w_full && !rd_pkt_info) begin
         r_overflow <= 1'b1;
      end
   end

   assign pkt_info_vld      = !w_empty;
   assign pkt_info          = w_empty ? 7'd0 : r_mem[r_rd_ptr];
   assign pkt_info_overflow = r_overflow;

endmodule

`default_nettype wire
